// File: rtl/commit_queue.sv
// commit_queue: multi-lane in-order commit FIFO. Accepts up to NLANE retiring
// instructions per cycle, drains one per cycle under valid/ready, and keeps a
// 64-bit retired-instruction counter plus an idle indicator.
module commit_queue #(
  parameter int unsigned NLANE = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NLANE-1:0]      in_valid,
  input  logic [32*NLANE-1:0]   in_inst,
  input  logic [64*NLANE-1:0]   in_pc,
  input  logic [NLANE-1:0]      in_skip,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [31:0]           out_inst,
  output logic [63:0]           out_pc,
  output logic                  out_skip,
  input  logic                  out_ready,
  output logic [63:0]           retired,
  output logic                  ok
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        skip;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic [63:0]     r_retired;

  logic [CW-1:0]   w_nenq;
  logic [PW-1:0]   w_wr_addr [NLANE];
  entry_t          w_wr_entry [NLANE];
  logic            w_enq;
  logic            w_deq;
  logic            w_nonempty;
  logic [CW-1:0]   w_count_next;
  logic            w_in_ready_next;
  entry_t          w_head_entry;

  // Compact valid lanes: each valid lane lands at tail + (number of valid lanes below it)
  always_comb begin
    w_nenq = '0;
    for (int i = 0; i < NLANE; i++) begin
      w_wr_addr[i]  = r_tail + PW'(w_nenq);
      w_wr_entry[i] = '{inst: in_inst[32*i +: 32], pc: in_pc[64*i +: 64], skip: in_skip[i]};
      w_nenq        = w_nenq + CW'(in_valid[i]);
    end
  end

  // Handshake decode, next occupancy and combinational head view
  always_comb begin
    w_nonempty      = (r_count != '0);
    w_enq           = r_in_ready && (|in_valid) && !flush;
    out_valid       = w_nonempty && !flush;
    w_deq           = out_valid && out_ready;
    w_count_next    = '0;
    if (!flush) begin
      w_count_next = r_count + (w_enq ? w_nenq : CW'(0)) - CW'(w_deq);
    end
    w_in_ready_next = (CW'(DEPTH) - w_count_next) >= CW'(NLANE);
    w_head_entry    = r_mem[r_head];
    out_inst        = w_nonempty ? w_head_entry.inst : 32'd0;
    out_pc          = w_nonempty ? w_head_entry.pc   : 64'd0;
    out_skip        = w_nonempty ? w_head_entry.skip : 1'b0;
    ok              = !w_nonempty && !(|in_valid);
  end

  // Pointers, occupancy, registered in_ready and retired counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
      r_retired  <= 64'd0;
    end else begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + PW'(w_nenq);
        if (w_deq) r_head <= r_head + PW'(1);
      end
      r_count    <= w_count_next;
      r_in_ready <= w_in_ready_next;
      if (w_deq) r_retired <= r_retired + 64'd1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (w_enq && in_valid[i]) r_mem[w_wr_addr[i]] <= w_wr_entry[i];
    end
  end

  assign in_ready = r_in_ready;
  assign retired  = r_retired;

endmodule

// File: tb/tb_commit_queue.sv
// Directed testbench for commit_queue (NLANE=2, DEPTH=8).
module tb_commit_queue;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in_valid = '0;
  logic [63:0]  in_inst = '0;
  logic [127:0] in_pc = '0;
  logic [1:0]   in_skip = '0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         out_valid;
  logic [31:0]  out_inst;
  logic [63:0]  out_pc;
  logic         out_skip;
  logic         out_ready = 1'b0;
  logic [63:0]  retired;
  logic         ok;

  int total = 0;
  int bad   = 0;

  commit_queue #(.NLANE(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_skip(in_skip),
    .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_skip(out_skip),
    .out_ready(out_ready), .retired(retired), .ok(ok)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] inst, input logic [63:0] pc, input logic skip);
    in_inst[32*l +: 32] = inst;
    in_pc[64*l +: 64]   = pc;
    in_skip[l]          = skip;
  endtask

  task automatic test_reset;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_in_reset_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_ok got=%b exp=1", ok); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_single;
    tick;
    set_lane(0, 32'h00000013, 64'h80000000, 1'b0);
    in_valid  = 2'b01;
    out_ready = 1'b1;
    #1;
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL single_ok_busy got=%b exp=0", ok); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
    tick;
    in_valid = 2'b00;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 64'h80000000) begin bad++; $display("FAIL single_out_pc got=%h exp=80000000", out_pc); end
    total++; if (out_inst !== 32'h00000013) begin bad++; $display("FAIL single_out_inst got=%h exp=13", out_inst); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL single_retired0 got=%0d exp=0", retired); end
    tick;
    total++; if (retired !== 64'd1) begin bad++; $display("FAIL single_retired1 got=%0d exp=1", retired); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_ok got=%b exp=1", ok); end
  endtask

  task automatic test_dual_sparse;
    set_lane(0, 32'h11, 64'h80000004, 1'b0);
    set_lane(1, 32'h22, 64'h80000008, 1'b1);
    in_valid = 2'b11;
    tick;
    set_lane(0, 32'hffff, 64'hdead, 1'b1);
    set_lane(1, 32'h33, 64'h8000000c, 1'b0);
    in_valid = 2'b10;
    #1;
    total++; if (out_pc !== 64'h80000004) begin bad++; $display("FAIL dual_pc_a got=%h exp=80000004", out_pc); end
    total++; if (out_skip !== 1'b0) begin bad++; $display("FAIL dual_skip_a got=%b exp=0", out_skip); end
    tick;
    in_valid = 2'b00;
    #1;
    total++; if (out_pc !== 64'h80000008) begin bad++; $display("FAIL dual_pc_b got=%h exp=80000008", out_pc); end
    total++; if (out_inst !== 32'h22) begin bad++; $display("FAIL dual_inst_b got=%h exp=22", out_inst); end
    total++; if (out_skip !== 1'b1) begin bad++; $display("FAIL dual_skip_b got=%b exp=1", out_skip); end
    tick;
    total++; if (out_pc !== 64'h8000000c) begin bad++; $display("FAIL sparse_pc_c got=%h exp=8000000c", out_pc); end
    total++; if (out_inst !== 32'h33) begin bad++; $display("FAIL sparse_inst_c got=%h exp=33", out_inst); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dual_drained got=%b exp=0", out_valid); end
    total++; if (retired !== 64'd4) begin bad++; $display("FAIL dual_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_fill;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 32'(2*k), 64'h1000 + 64'(16*k), 1'b0);
      set_lane(1, 32'(2*k+1), 64'h1008 + 64'(16*k), 1'b0);
      in_valid = 2'b11;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b exp=1", k, in_ready); end
      tick;
    end
    set_lane(0, 32'hbad0, 64'hbad0, 1'b0);
    set_lane(1, 32'hbad1, 64'hbad1, 1'b0);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    tick;
    in_valid = 2'b01;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_one_lane got=%b exp=0", in_ready); end
    total++; if (out_pc !== 64'h1000) begin bad++; $display("FAIL full_head got=%h exp=1000", out_pc); end
    in_valid  = 2'b00;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid_%0d got=%b exp=1", j, out_valid); end
      total++; if (out_pc !== 64'h1000 + 64'(8*j)) begin bad++; $display("FAIL drain_pc_%0d got=%h exp=%h", j, out_pc, 64'h1000 + 64'(8*j)); end
      total++; if (in_ready !== (j >= 2)) begin bad++; $display("FAIL drain_ready_%0d got=%b exp=%b", j, in_ready, (j >= 2)); end
      tick;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    total++; if (retired !== 64'd12) begin bad++; $display("FAIL drain_retired got=%0d exp=12", retired); end
    tick;
    total++; if (retired !== 64'd12) begin bad++; $display("FAIL empty_ready_hold got=%0d exp=12", retired); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL empty_pc_zero got=%h exp=0", out_pc); end
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL wrap_reset_retired got=%0d exp=0", retired); end
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_lane(0, 32'(k), 64'h2000 + 64'(4*k), 1'b0);
      in_valid = 2'b01;
      tick;
      total++; if (out_pc !== 64'h2000 + 64'(4*k)) begin bad++; $display("FAIL wrap_pre_pc_%0d got=%h exp=%h", k, out_pc, 64'h2000 + 64'(4*k)); end
    end
    in_valid = 2'b00;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_pre_empty got=%b exp=0", out_valid); end
    set_lane(0, 32'haa, 64'h3000, 1'b0);
    set_lane(1, 32'hbb, 64'h3008, 1'b1);
    in_valid = 2'b11;
    tick;
    in_valid = 2'b00;
    #1;
    total++; if (out_pc !== 64'h3000) begin bad++; $display("FAIL wrap_pc_slot7 got=%h exp=3000", out_pc); end
    total++; if (out_inst !== 32'haa) begin bad++; $display("FAIL wrap_inst_slot7 got=%h exp=aa", out_inst); end
    tick;
    total++; if (out_pc !== 64'h3008) begin bad++; $display("FAIL wrap_pc_slot0 got=%h exp=3008", out_pc); end
    total++; if (out_skip !== 1'b1) begin bad++; $display("FAIL wrap_skip_slot0 got=%b exp=1", out_skip); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%b exp=0", out_valid); end
    total++; if (retired !== 64'd9) begin bad++; $display("FAIL wrap_retired got=%0d exp=9", retired); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    set_lane(0, 32'h40, 64'h4000, 1'b0);
    set_lane(1, 32'h41, 64'h4008, 1'b0);
    in_valid = 2'b11;
    tick;
    tick;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%b exp=1", out_valid); end
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_same_cycle_valid got=%b exp=0", out_valid); end
    tick;
    flush    = 1'b0;
    in_valid = 2'b00;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_next_valid got=%b exp=0", out_valid); end
    total++; if (retired !== 64'd9) begin bad++; $display("FAIL flush_retired got=%0d exp=9", retired); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_ok got=%b exp=1", ok); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_later_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    set_lane(0, 32'h50, 64'h5000, 1'b0);
    set_lane(1, 32'h51, 64'h5008, 1'b0);
    in_valid = 2'b11;
    tick;
    tick;
    in_valid = 2'b01;
    tick;
    in_valid = 2'b00;
    total++; if (out_pc !== 64'h5000) begin bad++; $display("FAIL areset_pre_pc got=%h exp=5000", out_pc); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL areset_retired got=%0d exp=0", retired); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL areset_ok got=%b exp=1", ok); end
    rst = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_after_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_dual_sparse;
    test_fill;
    test_wrap;
    test_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
